// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream frame multiplexer.
//   state_t     : frame FSM state (IDLE / LOCKED)
//   rr_result_t : round-robin search result (found flag + winning index)
//   rr_next()   : round-robin search over up to MAX_CHANNELS request bits
package stream_mux_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int IDX_W        = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_result_t;

    // First set bit of valid[n-1:0], searching upward from ptr+1 and
    // wrapping modulo n. Bits at or above n are never considered.
    function automatic rr_result_t rr_next(
        input logic [MAX_CHANNELS-1:0] valid,
        input logic [IDX_W-1:0]        ptr,
        input int                      n
    );
        rr_result_t r;
        int         idx;
        r = '0;
        for (int k = 1; k <= MAX_CHANNELS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && !r.found && valid[idx[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search.
// Ports:
//   valid : per-channel request bits
//   ptr   : last winner; the search starts at ptr+1
//   found : some request bit is set
//   idx   : winning channel (valid only when found=1)
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [CHANNELS-1:0]  valid,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [SEL_WIDTH-1:0] idx
);

    rr_result_t r;

    always_comb begin
        r     = rr_next(MAX_CHANNELS'(valid), IDX_W'(ptr), CHANNELS);
        found = r.found;
        idx   = SEL_WIDTH'(r.idx);
    end

endmodule

// File: rtl/stream_frame_multiplexer.sv
// Registered N-to-1 valid/ready stream multiplexer with frame locking.
// A channel picked by select (ROUND_ROBIN=0) or by round-robin arbitration
// (ROUND_ROBIN=1) owns the output until its beat flagged last transfers.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   select              : requested channel (ignored in round-robin mode)
//   in_data/valid/last  : CHANNELS input streams, channel i at [i*WIDTH +: WIDTH]
//   in_ready            : per-channel accept, one-hot or zero
//   out_data/valid/last : registered output beat
//   out_ready           : downstream accept
module stream_frame_multiplexer
    import stream_mux_pkg::*;
#(
    parameter int  WIDTH       = 16,
    parameter int  CHANNELS    = 4,
    parameter int  ROUND_ROBIN = 0,
    localparam int SEL_WIDTH   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_WIDTH-1:0]      select,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready
);

    state_t               state, state_n;
    logic [SEL_WIDTH-1:0] grant;
    logic [SEL_WIDTH-1:0] rr_ptr;
    logic                 cand_found;
    logic [SEL_WIDTH-1:0] cand_idx;
    logic [SEL_WIDTH-1:0] xfer_idx;
    logic                 stage_free;
    logic                 xfer;

    // Candidate channel while no frame is in progress
    generate
        if (ROUND_ROBIN != 0) begin : g_rr
            rr_arbiter #(
                .CHANNELS  (CHANNELS),
                .SEL_WIDTH (SEL_WIDTH)
            ) u_arb (
                .valid (in_valid),
                .ptr   (rr_ptr),
                .found (cand_found),
                .idx   (cand_idx)
            );
        end else begin : g_sel
            // select may exceed CHANNELS-1 when CHANNELS is not a power of two
            always_comb begin
                cand_found = 1'b0;
                cand_idx   = select;
                if (int'(select) < CHANNELS) cand_found = in_valid[select];
            end
        end
    endgenerate

    // Output register can take a new beat this cycle
    assign stage_free = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        xfer_idx = (state == LOCKED) ? grant : cand_idx;
        if (!reset && stage_free) begin
            if (state == LOCKED) in_ready[grant] = 1'b1;
            else if (cand_found) in_ready[cand_idx] = 1'b1;
        end
    end

    // in_ready is one-hot or zero, so any overlap is the chosen channel
    assign xfer = |(in_valid & in_ready);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (xfer && !in_last[xfer_idx]) state_n = LOCKED;
            LOCKED:  if (xfer && in_last[xfer_idx])  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= SEL_WIDTH'(CHANNELS - 1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                if (state == IDLE) begin
                    grant  <= xfer_idx;
                    rr_ptr <= xfer_idx;
                end
                out_valid <= 1'b1;
                out_data  <= in_data[int'(xfer_idx)*WIDTH +: WIDTH];
                out_last  <= in_last[xfer_idx];
            end else if (stage_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_multiplexer.sv
// Self-checking bench for stream_frame_multiplexer.
// Three instances: a_ (select mode, 4 ch), b_ (round-robin, 4 ch),
// c_ (select mode, 3 ch). Directed steps followed by a randomized run on
// the round-robin instance against a frame-level reference model.
module tb_stream_frame_multiplexer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_out_valid, a_out_last, a_out_ready;
    logic [1:0]  a_select;
    logic [63:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_last, a_in_ready;
    logic [15:0] a_out_data;

    logic        b_reset, b_out_valid, b_out_last, b_out_ready;
    logic [1:0]  b_select;
    logic [63:0] b_in_data;
    logic [3:0]  b_in_valid, b_in_last, b_in_ready;
    logic [15:0] b_out_data;

    logic        c_reset, c_out_valid, c_out_last, c_out_ready;
    logic [1:0]  c_select;
    logic [47:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_last, c_in_ready;
    logic [15:0] c_out_data;

    stream_frame_multiplexer #(.WIDTH(16), .CHANNELS(4), .ROUND_ROBIN(0)) dut_a (
        .clk(clk), .reset(a_reset), .select(a_select), .in_data(a_in_data),
        .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
        .out_ready(a_out_ready));

    stream_frame_multiplexer #(.WIDTH(16), .CHANNELS(4), .ROUND_ROBIN(1)) dut_b (
        .clk(clk), .reset(b_reset), .select(b_select), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
        .out_ready(b_out_ready));

    stream_frame_multiplexer #(.WIDTH(16), .CHANNELS(3), .ROUND_ROBIN(0)) dut_c (
        .clk(clk), .reset(c_reset), .select(c_select), .in_data(c_in_data),
        .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_last(c_out_last),
        .out_ready(c_out_ready));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized run
    logic [11:0] seq [4];
    logic [3:0]  lastf;
    logic        m_ov, m_ol, locked;
    logic [15:0] m_od;
    logic [1:0]  lock_ch, last_ch, ri, ch;
    logic [3:0]  exp_rdy, acc;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_select = '0;  b_select = '0;  c_select = '0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_in_valid = 4'hF; b_in_valid = 4'hF; c_in_valid = '0;
        a_in_last = '0; b_in_last = '0; c_in_last = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;

        // ---- reset state ----
        step(); step();
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data",  a_out_data,  16'h0);
        chk("rst_out_last",  a_out_last,  1'b0);
        chk("rst_ready_a",   a_in_ready,  4'b0000);
        chk("rst_ready_b",   b_in_ready,  4'b0000);
        chk("rst_out_valid_b", b_out_valid, 1'b0);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        a_in_valid = '0; b_in_valid = '0;
        step();

        // ---- select mode: 3-beat frame on ch2, select moves to 1 mid-frame ----
        a_select = 2'd2;
        a_in_valid = 4'b0100; a_in_last = 4'b0000; a_in_data[32 +: 16] = 16'hA001;
        #1 chk("sel_ready1", a_in_ready, 4'b0100);
        step();
        chk("sel_ov1", a_out_valid, 1'b1);
        chk("sel_od1", a_out_data, 16'hA001);
        chk("sel_ol1", a_out_last, 1'b0);
        a_select = 2'd1;
        a_in_valid = 4'b0110; a_in_data[16 +: 16] = 16'hBEEF; a_in_data[32 +: 16] = 16'hA002;
        #1 chk("sel_ready2", a_in_ready, 4'b0100);
        step();
        chk("sel_od2", a_out_data, 16'hA002);
        chk("sel_ol2", a_out_last, 1'b0);
        a_in_data[32 +: 16] = 16'hA003; a_in_last = 4'b0100;
        #1 chk("sel_ready3", a_in_ready, 4'b0100);
        step();
        chk("sel_ov3", a_out_valid, 1'b1);
        chk("sel_od3", a_out_data, 16'hA003);
        chk("sel_ol3", a_out_last, 1'b1);

        // ---- select ch1 now that ch2's frame is done, then backpressure ----
        a_in_valid = 4'b0010; a_in_last = 4'b0000; a_in_data[16 +: 16] = 16'h1234;
        #1 chk("sel_ready_ch1", a_in_ready, 4'b0010);
        step();
        chk("bp_od0", a_out_data, 16'h1234);
        a_out_ready = 1'b0;
        a_in_data[16 +: 16] = 16'h1235;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", a_in_ready, 4'b0000);
            step();
            chk("bp_ov", a_out_valid, 1'b1);
            chk("bp_od", a_out_data, 16'h1234);
        end
        a_out_ready = 1'b1;
        #1 chk("bp_ready_rel", a_in_ready, 4'b0010);
        step();
        chk("bp_od_next", a_out_data, 16'h1235);
        a_in_valid = '0;
        step();
        chk("bp_drain_ov", a_out_valid, 1'b0);

        // ---- round robin: four single-beat channels ----
        b_in_valid = 4'hF; b_in_last = 4'hF;
        b_in_data = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", b_in_ready, 4'b0001 << (k % 4));
            step();
            chk("rr_ov", b_out_valid, 1'b1);
            chk("rr_od", b_out_data, 32'(k % 4));
            chk("rr_ol", b_out_last, 1'b1);
        end

        // ---- bubble inside a lock on ch1 while ch3 waits ----
        b_in_valid = 4'b0010; b_in_last = 4'b0000; b_in_data[16 +: 16] = 16'h1100;
        #1 chk("bub_ready0", b_in_ready, 4'b0010);
        step();
        chk("bub_od0", b_out_data, 16'h1100);
        b_in_valid = 4'b1000; b_in_last = 4'b1000; b_in_data[48 +: 16] = 16'h3333;
        for (int k = 0; k < 2; k++) begin
            #1 chk("bub_ready_hold", b_in_ready, 4'b0010);
            step();
            chk("bub_ov", b_out_valid, 1'b0);
        end
        b_in_valid = 4'b1010; b_in_last = 4'b1010; b_in_data[16 +: 16] = 16'h1101;
        #1 chk("bub_ready_last", b_in_ready, 4'b0010);
        step();
        chk("bub_od_last", b_out_data, 16'h1101);
        chk("bub_ol_last", b_out_last, 1'b1);
        b_in_valid = 4'b1000;
        #1 chk("bub_ready_ch3", b_in_ready, 4'b1000);
        step();
        chk("bub_od_ch3", b_out_data, 16'h3333);

        // ---- reset mid-frame on ch2 ----
        b_in_valid = 4'b0100; b_in_last = 4'b0000; b_in_data[32 +: 16] = 16'h2201;
        #1 chk("rmf_ready1", b_in_ready, 4'b0100);
        step();
        chk("rmf_od1", b_out_data, 16'h2201);
        b_in_data[32 +: 16] = 16'h2202;
        step();
        chk("rmf_od2", b_out_data, 16'h2202);
        b_reset = 1'b1;
        b_in_valid = 4'b0101; b_in_last = 4'b0001; b_in_data[0 +: 16] = 16'h0C00;
        #1 chk("rmf_ready_rst", b_in_ready, 4'b0000);
        step();
        chk("rmf_ov_after", b_out_valid, 1'b0);
        b_reset = 1'b0;
        #1 chk("rmf_ready_ch0", b_in_ready, 4'b0001);
        step();
        chk("rmf_od_ch0", b_out_data, 16'h0C00);
        b_in_valid = '0;

        // ---- out-of-range select on the 3-channel instance ----
        c_select = 2'd3; c_in_valid = 3'b111; c_in_last = 3'b111;
        c_in_data[32 +: 16] = 16'hC2C2;
        #1 chk("oor_ready", c_in_ready, 3'b000);
        step();
        chk("oor_ov1", c_out_valid, 1'b0);
        step();
        chk("oor_ov2", c_out_valid, 1'b0);
        c_select = 2'd2;
        #1 chk("oor_ready_ch2", c_in_ready, 3'b100);
        step();
        chk("oor_od_ch2", c_out_data, 16'hC2C2);

        // ---- randomized round-robin run against the frame-level model ----
        b_in_valid = '0; b_out_ready = 1'b1; b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq[i]   = '0;
            lastf[i] = ($urandom_range(0, 2) == 0);
        end
        m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
        locked = 1'b0; lock_ch = '0; last_ch = 2'd3;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_ov", b_out_valid, m_ov);
            if (m_ov) begin
                chk("rnd_od", b_out_data, m_od);
                chk("rnd_ol", b_out_last, m_ol);
            end
            for (int i = 0; i < 4; i++) begin
                b_in_valid[i]          = ($urandom_range(0, 2) != 0);
                b_in_data[i*16 +: 16]  = {4'(i), seq[i]};
                b_in_last[i]           = lastf[i];
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            // Frame owner holds the port; otherwise first valid after last winner
            exp_rdy = '0;
            if (!m_ov || b_out_ready) begin
                if (locked) exp_rdy[lock_ch] = 1'b1;
                else
                    for (int k = 1; k <= 4; k++) begin
                        ri = last_ch + 2'(k);
                        if (exp_rdy == 4'b0 && b_in_valid[ri]) exp_rdy[ri] = 1'b1;
                    end
            end
            chk("rnd_ready", b_in_ready, exp_rdy);
            acc = b_in_valid & exp_rdy;
            if (acc != 4'b0) begin
                ch = '0;
                for (int i = 0; i < 4; i++) if (acc[i]) ch = 2'(i);
                m_ov = 1'b1; m_od = {2'b00, ch, seq[ch]}; m_ol = lastf[ch];
                if (!locked) last_ch = ch;
                locked  = !lastf[ch];
                lock_ch = ch;
                seq[ch]   = seq[ch] + 12'd1;
                lastf[ch] = ($urandom_range(0, 2) == 0);
            end else if (!m_ov || b_out_ready) begin
                m_ov = 1'b0;
            end
            step();
        end
        chk("rnd_ov_end", b_out_valid, m_ov);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_frame_multiplexer.md
# stream_frame_multiplexer

Parametrised, registered N-to-1 multiplexer for valid/ready streams with frame locking. It replaces fixed two-input muxing wherever several producers (pattern generators, host-loaded frame buffers, test sources) share one downstream consumer such as the LED panel writer. The channel is chosen either by an external select or by round-robin arbitration. Once a channel is granted, it is held until the beat flagged `last` has been transferred.

## Interface
- `WIDTH`, 16, data bits per beat
- `CHANNELS`, 4, number of input streams (2..16)
- `ROUND_ROBIN`, 0, 0 = channel chosen by `select`; 1 = round-robin arbitration (`select` ignored)
- `SEL_WIDTH`, `$clog2(CHANNELS)`, width of `select` and of the grant (local parameter, not overridable)

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `select`  in  SEL_WIDTH  requested channel when ROUND_ROBIN=0
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  CHANNELS  per-channel beat valid
- `in_last`  in  CHANNELS  per-channel end-of-frame flag
- `in_ready`  out  CHANNELS  per-channel accept; one-hot or zero
- `out_data`  out  WIDTH  registered data
- `out_valid`  out  1  registered valid
- `out_last`  out  1  registered end-of-frame
- `out_ready`  in  1  downstream accept

## Operation
- FSM has two states:
  - IDLE: no frame in progress.
  - LOCKED: `grant` register owns the output until its last beat.
- Candidate selection in IDLE:
  - ROUND_ROBIN=0: the candidate is `select`, provided `select` < CHANNELS and `in_valid[select]`=1. Otherwise there is no candidate.
  - ROUND_ROBIN=1: the candidate is the first channel with `in_valid` set, searching upward from `rr_ptr`+1 modulo CHANNELS.
- Stage free: `out_valid`=0 or `out_ready`=1.
- `in_ready[i]`=1 when the stage is free and channel i is either the IDLE candidate or the LOCKED grant. It is combinational from state, `in_valid`, `select` and `out_ready`.
- A transfer occurs on channel i when `in_valid[i]` and `in_ready[i]` are both high. The beat is loaded into the output register.
- On a transfer in IDLE:
  - `grant` is set to i.
  - `rr_ptr` is set to i.
  - If `in_last[i]`=0 the FSM moves to LOCKED; if `in_last[i]`=1 it stays in IDLE (single-beat frame).
- On a transfer in LOCKED with `in_last`=1: return to IDLE.
- In LOCKED:
  - `select` changes and valid beats on other channels are ignored.
  - A grant channel with `in_valid`=0 produces bubbles; the lock is held indefinitely.
- When `out_valid`=1 and `out_ready`=0, the output register holds `out_data`/`out_valid`/`out_last` stable. No input is accepted.
- When the stage is free and no transfer occurs, `out_valid` clears on that edge.

## Timing
- Latency: a beat accepted on edge N appears on the outputs after edge N; exactly 1 cycle.
- Throughput: 1 beat/cycle sustained, including back-to-back frames from different channels. There is no idle cycle between frames.
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, state=IDLE, `grant`=0, `rr_ptr`=CHANNELS-1 (so channel 0 wins first), `in_ready`=0 while `reset` is high.
- Reset mid-frame: the partial frame is abandoned and the output register is emptied. After reset deasserts, arbitration restarts from IDLE. Downstream must tolerate a truncated frame.
- `out_ready` may be driven combinationally by downstream.
- `in_valid` must not be made to depend on `in_ready`.

## Structure
- Shared package `stream_mux_pkg`:
  - FSM state enum (IDLE, LOCKED).
  - Function `rr_next(valid, ptr)` returning the next round-robin winner and a found flag.
- Sub-module `rr_arbiter`: combinational round-robin priority search over CHANNELS bits. It is instantiated only when ROUND_ROBIN=1.
- The top module holds the FSM, the `grant` and `rr_ptr` registers, and the output register.

## Test plan
- ROUND_ROBIN=0, CHANNELS=4, WIDTH=16:
  - Stimulus: `select`=2; ch2 sends 0xA001, 0xA002, then 0xA003 with last; `select` switches to 1 after the first beat.
  - Required: outputs 0xA001..0xA003 on consecutive cycles; the third beat has `out_last`=1; `in_ready[1]`=0 throughout.
- ROUND_ROBIN=1, all four channels valid, single-beat frames with data 0x0i:
  - Required: output order 0x00, 0x01, 0x02, 0x03, 0x00; one beat per cycle.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles while `out_valid`=1 with data 0x1234.
  - Required: `out_data` stays 0x1234; all `in_ready`=0; the next beat appears in the cycle after `out_ready` rises.
- Bubble inside a lock:
  - Stimulus: ch1 drops `in_valid` for 2 cycles mid-frame while ch3 is valid.
  - Required: `out_valid`=0 for 2 cycles; ch3 is not granted until ch1's last beat has transferred.
- Out-of-range select:
  - Stimulus: CHANNELS=3, `select`=3.
  - Required: `in_ready`=000; `out_valid` stays 0.
- Reset mid-frame:
  - Stimulus: assert `reset` for 1 cycle after the second beat of a 4-beat frame on ch2.
  - Required: `out_valid`=0 the next cycle; in round-robin mode ch0 is granted first afterwards.
